branch_target_buffer: RTL and testbench

Direct-mapped branch target buffer and prediction tracker for the RISC-V Lite pipeline. It sits beside the IF stage, upstream of the hazard unit's PCSrc selection. It predicts the next fetch PC from the current PC, carries each prediction through IF/ID and ID/EX in lock-step with the pipeline, and compares it with the outcome resolved in EX. It raises a mispredict with a corrected PC and updates its entries with the resolved outcome.

---
 rtl/my_pkg.sv | 19 +
 rtl/btb_entry_array.sv | 37 +++
 rtl/branch_target_buffer.sv | 109 ++++++++++
 tb/tb_branch_target_buffer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// Shared pipeline types: branch cache entry and the BTB prediction slot carried down the pipe.
package my_pkg;

    typedef struct packed {
        logic        V;
        logic [5:0]  TAG;
        logic [31:0] TA;
        logic        T;
    } CACHE_BRANCH;

    localparam int unsigned BTB_TAG_W = 6;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] target;
    } BTB_PRED_SLOT;

endpackage

// File: rtl/btb_entry_array.sv
// Direct-mapped BTB storage: one combinational read port, one resolve-driven write port,
// asynchronous clear of every entry.
module btb_entry_array import my_pkg::*; #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     rd_idx,
    output CACHE_BRANCH          rd_entry,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [BTB_TAG_W-1:0] wr_tag,
    input  logic [31:0]          wr_target,
    input  logic                 wr_taken
);

    CACHE_BRANCH entries_q [ENTRIES];

    assign rd_entry = entries_q[rd_idx];

    // Taken outcomes overwrite the slot outright; not-taken only demotes a matching entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entries_q[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_taken) begin
                entries_q[wr_idx] <= '{V: 1'b1, TAG: wr_tag, TA: wr_target, T: 1'b1};
            end else if (entries_q[wr_idx].V && (entries_q[wr_idx].TAG == wr_tag)) begin
                entries_q[wr_idx].T <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Branch target buffer beside IF: predicts the next fetch PC, carries the prediction to EX
// alongside the instruction, and flags/corrects mispredicts against the resolved outcome.
module branch_target_buffer import my_pkg::*; #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    input  logic        en_pc,
    input  logic        en_ifid,
    input  logic        bubble_ex,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [15:0] stat_mispredicts
);

    logic [IDX_W-1:0]     if_idx;
    logic [IDX_W-1:0]     res_idx;
    logic [BTB_TAG_W-1:0] if_tag;
    logic [BTB_TAG_W-1:0] res_tag;
    CACHE_BRANCH          rd_entry;
    logic                 hit;

    BTB_PRED_SLOT pf_if_q;
    BTB_PRED_SLOT ifid_q;
    BTB_PRED_SLOT idex_q;

    logic        res_act;
    logic        eff_taken;
    logic [31:0] eff_target;
    logic [31:0] res_pc_inc;
    logic [15:0] stat_q;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[IDX_W+BTB_TAG_W+1:IDX_W+2];
    assign res_idx = res_pc[IDX_W+1:2];
    assign res_tag = res_pc[IDX_W+BTB_TAG_W+1:IDX_W+2];

    btb_entry_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_idx),
        .rd_entry  (rd_entry),
        .wr_en     (res_valid),
        .wr_idx    (res_idx),
        .wr_tag    (res_tag),
        .wr_target (res_target),
        .wr_taken  (res_taken)
    );

    always_comb begin
        hit         = rd_entry.V && (rd_entry.TAG == if_tag);
        pred_taken  = hit && rd_entry.T;
        pred_target = pred_taken ? rd_entry.TA : if_pc + 32'd4;
    end

    // An empty ID/EX slot behaves as a not-taken, fall-through prediction.
    always_comb begin
        res_act     = res_valid && rst_n;
        res_pc_inc  = res_pc + 32'd4;
        eff_taken   = idex_q.valid && idex_q.taken;
        eff_target  = idex_q.valid ? idex_q.target : res_pc_inc;
        mispredict  = res_act && ((eff_taken != res_taken) ||
                                  (res_taken && (eff_target != res_target)));
        redirect_pc = !res_act ? 32'd0 : (res_taken ? res_target : res_pc_inc);
    end

    // Flush takes priority over stalls and bubbles so no stale prediction survives a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_if_q <= '0;
            ifid_q  <= '0;
            idex_q  <= '0;
        end else if (mispredict) begin
            pf_if_q <= '0;
            ifid_q  <= '0;
            idex_q  <= '0;
        end else begin
            if (en_pc) begin
                pf_if_q <= '{valid: 1'b1, taken: pred_taken, target: pred_target};
            end
            if (en_ifid) begin
                ifid_q <= pf_if_q;
            end
            idex_q <= bubble_ex ? '0 : ifid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (mispredict && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_mispredicts = stat_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: the driver queues expected values per cycle,
// the negedge monitor pops and compares them against the DUT.
module tb_branch_target_buffer;

    localparam int SelPt    = 0;
    localparam int SelPtg   = 1;
    localparam int SelMis   = 2;
    localparam int SelRedir = 3;
    localparam int SelStat  = 4;
    localparam int SelSlots = 5;
    localparam int SelVbits = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc;
    logic        en_pc;
    logic        en_ifid;
    logic        bubble_ex;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] stat_mispredicts;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .en_pc            (en_pc),
        .en_ifid          (en_ifid),
        .bubble_ex        (bubble_ex),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        exp_q.push_back(c);
    endtask

    task automatic idle_inputs();
        en_pc      = 1'b1;
        en_ifid    = 1'b1;
        bubble_ex  = 1'b0;
        res_valid  = 1'b0;
        res_pc     = 32'd0;
        res_taken  = 1'b0;
        res_target = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        res_valid  = 1'b1;
        res_pc     = pc;
        res_taken  = taken;
        res_target = tgt;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c   = exp_q.pop_front();
            act = 32'd0;
            case (c.sel)
                SelPt:    act = {31'd0, pred_taken};
                SelPtg:   act = pred_target;
                SelMis:   act = {31'd0, mispredict};
                SelRedir: act = redirect_pc;
                SelStat:  act = {16'd0, stat_mispredicts};
                SelSlots: act = {29'd0, dut.pf_if_q.valid, dut.ifid_q.valid, dut.idex_q.valid};
                SelVbits: begin
                    for (int i = 0; i < 16; i++) begin
                        act[i] = dut.u_array.entries_q[i].V;
                    end
                end
                default:  act = 32'hDEAD_BEEF;
            endcase
            total++;
            if (act !== c.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h at %0t", c.name, act, c.exp, $time);
            end
        end
    end

    initial begin
        idle_inputs();
        if_pc = 32'h100;
        #1;
        expect_val("rst_pt", SelPt, 32'd0);
        expect_val("rst_ptg", SelPtg, 32'h104);
        expect_val("rst_mis", SelMis, 32'd0);
        expect_val("rst_redir", SelRedir, 32'd0);
        expect_val("rst_stat", SelStat, 32'd0);
        expect_val("rst_slots", SelSlots, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // C1: train 0x100 -> 0x40 with empty ID/EX; same-cycle lookup sees old contents
        if_pc = 32'h100;
        resolve(32'h100, 1'b1, 32'h40);
        expect_val("c1_mis", SelMis, 32'd1);
        expect_val("c1_redir", SelRedir, 32'h40);
        expect_val("c1_pt_nobypass", SelPt, 32'd0);
        expect_val("c1_ptg_nobypass", SelPtg, 32'h104);

        next_cycle();  // C2
        if_pc = 32'h100;
        expect_val("c2_pt", SelPt, 32'd1);
        expect_val("c2_ptg", SelPtg, 32'h40);
        expect_val("c2_stat", SelStat, 32'd1);
        expect_val("c2_flushed", SelSlots, 32'd0);

        next_cycle();  // C3
        if_pc = 32'h100;
        next_cycle();  // C4
        if_pc = 32'h100;

        next_cycle();  // C5: C2 prediction now in EX
        resolve(32'h100, 1'b1, 32'h40);
        expect_val("c5_mis_correct", SelMis, 32'd0);
        expect_val("c5_redir", SelRedir, 32'h40);

        next_cycle();  // C6: C3 prediction in EX, resolves not-taken
        resolve(32'h100, 1'b0, 32'd0);
        expect_val("c6_mis_nt", SelMis, 32'd1);
        expect_val("c6_redir_nt", SelRedir, 32'h104);

        next_cycle();  // C7
        if_pc = 32'h100;
        expect_val("c7_pt_tclear", SelPt, 32'd0);
        expect_val("c7_ptg_tclear", SelPtg, 32'h104);
        expect_val("c7_stat", SelStat, 32'd2);

        next_cycle();  // C8: retrain
        resolve(32'h100, 1'b1, 32'h40);
        expect_val("c8_mis", SelMis, 32'd1);
        expect_val("c8_redir", SelRedir, 32'h40);

        next_cycle();  // C9: alias 0x500 shares index 0
        if_pc = 32'h100;
        resolve(32'h500, 1'b1, 32'h80);
        expect_val("c9_pt", SelPt, 32'd1);
        expect_val("c9_ptg", SelPtg, 32'h40);
        expect_val("c9_mis", SelMis, 32'd1);
        expect_val("c9_redir", SelRedir, 32'h80);

        next_cycle();  // C10
        if_pc = 32'h100;
        expect_val("c10_alias_pt", SelPt, 32'd0);
        expect_val("c10_alias_ptg", SelPtg, 32'h104);
        expect_val("c10_stat", SelStat, 32'd4);

        next_cycle();  // C11: not-taken miss, no write
        if_pc = 32'h500;
        resolve(32'h104, 1'b0, 32'd0);
        expect_val("c11_pt", SelPt, 32'd1);
        expect_val("c11_ptg", SelPtg, 32'h80);
        expect_val("c11_mis", SelMis, 32'd0);
        expect_val("c11_redir", SelRedir, 32'h108);

        next_cycle();  // C12
        if_pc = 32'h500;
        next_cycle();  // C13
        if_pc = 32'h500;
        next_cycle();  // C14
        if_pc = 32'h500;
        expect_val("c14_slots_full", SelSlots, 32'd7);

        next_cycle();  // C15: mispredict during full stall
        if_pc   = 32'h500;
        en_pc   = 1'b0;
        en_ifid = 1'b0;
        resolve(32'h500, 1'b0, 32'd0);
        expect_val("c15_mis", SelMis, 32'd1);
        expect_val("c15_redir", SelRedir, 32'h504);

        next_cycle();  // C16
        if_pc = 32'h500;
        expect_val("c16_flush_wins", SelSlots, 32'd0);
        expect_val("c16_stat", SelStat, 32'd5);
        expect_val("c16_pt", SelPt, 32'd0);
        expect_val("c16_ptg", SelPtg, 32'h504);

        next_cycle();  // C17
        if_pc = 32'h104;
        expect_val("c17_nowrite_pt", SelPt, 32'd0);
        expect_val("c17_nowrite_ptg", SelPtg, 32'h108);

        // Saturation: every cycle mispredicts since ID/EX is always flushed
        for (int n = 0; n < 65540; n++) begin
            next_cycle();
            if_pc = 32'h200;
            resolve(32'h200, 1'b1, 32'h300);
        end
        next_cycle();
        if_pc = 32'h200;
        resolve(32'h200, 1'b1, 32'h300);
        expect_val("sat_mis", SelMis, 32'd1);
        expect_val("sat_redir", SelRedir, 32'h300);
        expect_val("sat_stat", SelStat, 32'hFFFF);
        next_cycle();
        expect_val("sat_hold", SelStat, 32'hFFFF);
        expect_val("idle_mis", SelMis, 32'd0);
        expect_val("idle_redir", SelRedir, 32'd0);

        // Reset asserted alongside a pending update
        next_cycle();
        if_pc = 32'h100;
        resolve(32'h100, 1'b1, 32'h40);
        rst_n = 1'b0;
        expect_val("mrst_stat", SelStat, 32'd0);
        expect_val("mrst_vbits", SelVbits, 32'd0);
        expect_val("mrst_mis", SelMis, 32'd0);
        expect_val("mrst_redir", SelRedir, 32'd0);
        expect_val("mrst_pt", SelPt, 32'd0);
        expect_val("mrst_ptg", SelPtg, 32'h104);
        next_cycle();
        if_pc = 32'h100;
        expect_val("mrst_vbits_after_edge", SelVbits, 32'd0);
        rst_n = 1'b1;
        next_cycle();
        if_pc = 32'h100;
        expect_val("post_rst_pt", SelPt, 32'd0);
        expect_val("post_rst_ptg", SelPtg, 32'h104);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
